// File: rtl/cb_arbiter.sv
// cb_arbiter
//   Folds circuit-breaker requests from NREQ sources into the order book's
//   single cb_mode/cb_param/cb_load port. The most severe pending request wins
//   (ties go to the lowest index). A freshly issued command is protected from
//   equal/weaker requests for MIN_HOLD cycles. The arbiter falls back to IDLE
//   when the order book reports the breaker has self-healed (cb_active low).
//   clear_all forces NORMAL from any state.
//
//   Optional feature: define CBARB_ESCALATE_EN to enable THROTTLE->PAUSE
//   escalation. With it enabled, ESC_THRESH winning THROTTLE requests while
//   THROTTLE is held are escalated to PAUSE. The ESC_THRESH parameter only
//   exists in that build.
module cb_arbiter #(
  parameter int NREQ     = 3,
  parameter int MIN_HOLD = 16
`ifdef CBARB_ESCALATE_EN
  ,
  parameter int ESC_THRESH = 4
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [2*NREQ-1:0] req_mode,
  input  logic [8*NREQ-1:0] req_param,
  input  logic              clear_all,
  input  logic              cb_active,
  output logic [NREQ-1:0]   req_ack,
  output logic [NREQ-1:0]   req_drop,
  output logic [1:0]        cb_mode,
  output logic [7:0]        cb_param,
  output logic              cb_load,
  output logic [1:0]        cur_sev,
  output logic              busy,
  output logic [7:0]        issue_cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_HOLD    = 2'd2,
    S_ENGAGED = 2'd3
  } state_t;

  state_t          state;
  state_t          next_state;

  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic [1:0]      win_sev;
  logic [1:0]      win_mode;
  logic [7:0]      win_param;

  logic            do_ack;
  logic            do_drop;
  logic            do_issue;
  logic            do_heal;
  logic            clr_eff;
  logic [1:0]      dec_mode;
  logic [7:0]      dec_param;

  logic [IW-1:0]   owner;
  logic [HW-1:0]   hold_cnt;
  logic            clr_pend;

`ifdef CBARB_ESCALATE_EN
  logic [2:0]      esc_cnt;
  logic            esc_inc;
  logic            esc_hit;
`endif

  // Mode code doubles as severity: NORMAL < THROTTLE < WIDEN < PAUSE.
  function automatic logic [1:0] sev_of(input logic [1:0] mode);
    return mode;
  endfunction

  // Saturating 8-bit increment for the issue counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Winner selection: highest severity among valid requests, lowest index on a tie.
  always_comb begin
    win_vld   = 1'b0;
    win_idx   = '0;
    win_sev   = 2'd0;
    win_mode  = 2'd0;
    win_param = 8'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && (!win_vld || (sev_of(req_mode[2*i +: 2]) > win_sev))) begin
        win_vld   = 1'b1;
        win_idx   = IW'(i);
        win_sev   = sev_of(req_mode[2*i +: 2]);
        win_mode  = req_mode[2*i +: 2];
        win_param = req_param[8*i +: 8];
      end
    end
  end

  // Decision logic: ack/drop of the winner, issue request and self-heal.
  always_comb begin
    do_ack    = 1'b0;
    do_drop   = 1'b0;
    do_issue  = 1'b0;
    do_heal   = 1'b0;
    dec_mode  = win_mode;
    dec_param = win_param;
`ifdef CBARB_ESCALATE_EN
    esc_inc   = 1'b0;
    esc_hit   = 1'b0;
`endif
    // A clear seen while ISSUE was showing its load is replayed on the next cycle.
    clr_eff   = clear_all | clr_pend;
    case (state)
      S_IDLE: begin
        if (clr_eff) begin
          do_drop   = win_vld;
          do_issue  = 1'b1;
          dec_mode  = 2'b00;
          dec_param = 8'h00;
        end else if (win_vld) begin
          // NORMAL while already idle is accepted but needs no load.
          do_ack   = 1'b1;
          do_issue = (win_sev != 2'd0);
        end
      end
      S_HOLD, S_ENGAGED: begin
        if (clr_eff) begin
          do_drop   = win_vld;
          do_issue  = 1'b1;
          dec_mode  = 2'b00;
          dec_param = 8'h00;
        end else if (win_vld) begin
`ifdef CBARB_ESCALATE_EN
          esc_inc = (win_mode == 2'b01) && (cur_sev == 2'd1);
          esc_hit = esc_inc && (({1'b0, esc_cnt} + 4'd1) >= 4'(ESC_THRESH));
`endif
          if (win_sev > cur_sev) begin
            do_ack   = 1'b1;
            do_issue = 1'b1;
          end else if ((state == S_ENGAGED) &&
                       ((win_sev == cur_sev) ||
                        ((win_sev == 2'd0) && (win_idx == owner)))) begin
            // Equal severity refreshes the param; NORMAL releases only from the owner.
            do_ack   = 1'b1;
            do_issue = 1'b1;
          end else begin
            do_drop = 1'b1;
          end
`ifdef CBARB_ESCALATE_EN
          if (esc_hit) begin
            do_ack   = 1'b1;
            do_drop  = 1'b0;
            do_issue = 1'b1;
            dec_mode = 2'b11;
          end
`endif
        end
        // Breaker healed on its own and nothing new was accepted: release.
        if (!clr_eff && !do_ack && !cb_active) begin
          do_heal = 1'b1;
        end
      end
      default: begin
        // ISSUE: load cycle, no arbitration.
      end
    endcase
  end

  // Handshake vectors: only the winner ever sees ack or drop.
  always_comb begin
    req_ack           = '0;
    req_drop          = '0;
    req_ack[win_idx]  = do_ack;
    req_drop[win_idx] = do_drop;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (do_issue) next_state = S_ISSUE;
      end
      S_ISSUE: begin
        next_state = (cb_mode == 2'b00) ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        if (do_issue)              next_state = S_ISSUE;
        else if (do_heal)          next_state = S_IDLE;
        else if (hold_cnt == '0)   next_state = S_ENGAGED;
      end
      S_ENGAGED: begin
        if (do_issue)              next_state = S_ISSUE;
        else if (do_heal)          next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Issued command, held severity, ownership and hold timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cb_mode   <= 2'b00;
      cb_param  <= 8'h00;
      cb_load   <= 1'b0;
      cur_sev   <= 2'd0;
      issue_cnt <= 8'd0;
      owner     <= '0;
      hold_cnt  <= '0;
      clr_pend  <= 1'b0;
    end else begin
      cb_load <= do_issue;
      if (do_issue) begin
        cb_mode   <= dec_mode;
        cb_param  <= dec_param;
        cur_sev   <= sev_of(dec_mode);
        issue_cnt <= sat_inc8(issue_cnt);
        clr_pend  <= 1'b0;
      end else if (do_heal) begin
        cur_sev <= 2'd0;
      end
      if ((state == S_ISSUE) && clear_all) begin
        clr_pend <= 1'b1;
      end
      if (do_ack) begin
        owner <= win_idx;
      end
      if (state == S_ISSUE) begin
        hold_cnt <= HW'(MIN_HOLD - 1);
      end else if ((state == S_HOLD) && (hold_cnt != '0)) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

`ifdef CBARB_ESCALATE_EN
  // Escalation counter: winning THROTTLE requests while THROTTLE is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      esc_cnt <= 3'd0;
    end else if (do_issue && (dec_mode != 2'b01)) begin
      esc_cnt <= 3'd0;
    end else if ((next_state == S_IDLE) && (state != S_IDLE)) begin
      esc_cnt <= 3'd0;
    end else if (esc_inc && (esc_cnt != 3'd7)) begin
      esc_cnt <= esc_cnt + 3'd1;
    end
  end
`endif

  assign busy = (state != S_IDLE);

endmodule
